pipe_skid_reg: RTL and testbench
================================

Name: pipe_skid_reg

Overview:
- Parametrised pipeline-stage register with a valid/ready handshake and a 2-entry skid buffer, for use between MIPS pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Sustains one transfer per cycle.
- Fully registered outputs: no combinational path from in_* to out_*, and none from out_ready to in_ready.
- Supports a synchronous pipeline flush and an asynchronous clear.

Parameters:
- WIDTH, 32, payload width in bits (legal range 1..256).
- RESET_VAL, {WIDTH{1'b0}}, value loaded into both data registers on clr.

Ports:
- clk  input  1  clock, all state updates on the rising edge
- clr  input  1  reset, asynchronous, active-high
- flush  input  1  synchronous discard of all held entries
- in_valid  input  1  upstream payload valid
- in_ready  output  1  stage can accept; registered-state derived
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  downstream payload valid
- out_ready  input  1  downstream accepts
- out_data  output  WIDTH  downstream payload, driven directly from the main register
- occupancy  output  2  entries held: 0, 1 or 2

Behaviour:
- Reset:
  - clr asserted forces, immediately and without a clock: state=EMPTY, main=skid=RESET_VAL, out_valid=0, out_data=RESET_VAL, occupancy=0.
  - in_ready=0 while clr is high.
  - First accept can occur on the first rising edge after clr deasserts.
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Outputs:
  - in_ready = (state != TWO) & !clr.
  - out_valid = (state != EMPTY).
  - occupancy = state encoding.
- State transitions (per rising edge, flush=0):
  - EMPTY: in_fire -> ONE, main<=in_data. Otherwise hold.
  - ONE, in_fire & out_fire -> ONE, main<=in_data.
  - ONE, in_fire & !out_fire -> TWO, skid<=in_data; main unchanged.
  - ONE, !in_fire & out_fire -> EMPTY; main holds its stale value.
  - ONE, neither -> hold.
  - TWO: in_ready=0, so in_valid is ignored. out_fire -> ONE, main<=skid. Otherwise hold.
- Latency and ordering:
  - in_fire to out_valid: 1 cycle.
  - Strict FIFO order.
  - Throughput is 1/cycle when out_ready=1.
- Stability: while out_valid=1 and out_ready=0, out_data must not change.
- Flush:
  - flush=1 at an edge -> state=EMPTY at that edge, taking priority over all transitions.
  - A simultaneous in_fire completes the handshake but its data is discarded.
  - A simultaneous out_fire is considered consumed.
  - Data registers are not rewritten by flush.
- Priority: clr > flush > handshake.
- Don't-care inputs: in_data is never sampled when in_fire=0, so X on in_data must not reach out_data.
- Illegal state: encoding 2'b11 is unreachable. If entered, return to EMPTY on the next edge.

Decomposition:
- Shared package pipe_pkg:
  - localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2.
  - State width constant ST_W=2.
- One sub-module, pipe_data_reg:
  - WIDTH-wide register with load enable and asynchronous active-high clr to RESET_VAL.
  - Instantiated twice, as main and skid.
- Top level holds the state FSM and the enable muxing.

Test Plan:
1. Reset mid-operation: fill to TWO with 0x0000_000A then 0x0000_000B (out_ready=0), assert clr between edges -> same-cycle out_valid=0, out_data=0, occupancy=0, in_ready=0; after release, push 0x5 -> out_data=0x5 one cycle later.
2. Streaming: out_ready=1, in_valid=1 with data 1..8 on consecutive cycles -> out_data 1..8 on cycles 1..8 after each accept, in_ready stays 1, occupancy stays 1.
3. Backpressure: out_ready=0, push 0x11 then 0x22 -> occupancy=2, in_ready=0, third value 0x33 held upstream, out_data=0x11 stable. Raise out_ready -> outputs 0x11, 0x22, 0x33 in order, no loss or duplication.
4. Simultaneous events in ONE: in_fire & out_fire with 0x44 -> occupancy stays 1, out_data=0x44 next cycle.
5. Flush: state TWO, assert flush together with in_valid=1 -> next cycle out_valid=0, occupancy=0, in_ready=1; the flushed input never appears at out_data.
6. Parameter sweep: WIDTH=1 and WIDTH=64 with RESET_VAL=all-ones -> reset out_data all-ones; scenarios 2–3 pass unchanged.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared state encoding for the pipeline skid-register stage.
package pipe_pkg;

    localparam int ST_W = 2;

    localparam logic [ST_W-1:0] ST_EMPTY = 2'd0;
    localparam logic [ST_W-1:0] ST_ONE   = 2'd1;
    localparam logic [ST_W-1:0] ST_TWO   = 2'd2;

    // Encoding doubles as the occupancy count; 2'b11 is never entered.
    typedef enum logic [ST_W-1:0] {
        S_EMPTY = ST_EMPTY,
        S_ONE   = ST_ONE,
        S_TWO   = ST_TWO,
        S_BAD   = 2'd3
    } state_e;

endpackage

// File: rtl/pipe_data_reg.sv
// WIDTH-wide payload register with load enable; 1-cycle load, no handshake of its own.
// clr restores RESET_VAL immediately; a deasserted ld holds the value, so din is ignored.
module pipe_data_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (ld) begin
            data_d = din;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            data_q <= RESET_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign dout = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with 2-entry skid; in_fire to out_valid is 1 cycle, 1 transfer/cycle.
// in_ready drops only when both entries are full, so out_ready never reaches in_ready combinationally.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    state_e           state_d;
    state_e           state_q;
    logic             in_fire;
    logic             out_fire;
    logic             main_ld;
    logic             skid_ld;
    logic             main_from_skid;
    logic [WIDTH-1:0] main_din;
    logic [WIDTH-1:0] skid_dout;

    assign in_ready  = (state_q != S_TWO) && !clr;
    assign out_valid = (state_q != S_EMPTY);
    assign occupancy = state_q;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        skid_ld        = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (in_fire) begin
                    state_d = S_ONE;
                    main_ld = 1'b1;
                end
            end
            S_ONE: begin
                if (in_fire && out_fire) begin
                    main_ld = 1'b1;
                end else if (in_fire) begin
                    state_d = S_TWO;
                    skid_ld = 1'b1;
                end else if (out_fire) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (out_fire) begin
                    state_d        = S_ONE;
                    main_ld        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        // Flush empties the stage but leaves both data registers untouched.
        if (flush) begin
            state_d = S_EMPTY;
            main_ld = 1'b0;
            skid_ld = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign main_din = main_from_skid ? skid_dout : in_data;

    pipe_data_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk  (clk),
        .clr  (clr),
        .ld   (main_ld),
        .din  (main_din),
        .dout (out_data)
    );

    pipe_data_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk  (clk),
        .clr  (clr),
        .ld   (skid_ld),
        .din  (in_data),
        .dout (skid_dout)
    );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: three widths driven in lockstep, checked against a FIFO scoreboard.
module tb_pipe_skid_reg;

    logic        clk = 1'b0;
    logic        clr;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_data;
    logic [0:0]  in_data1;
    logic [63:0] in_data64;

    logic        in_ready32, in_ready1, in_ready64;
    logic        out_valid32, out_valid1, out_valid64;
    logic [31:0] out_data32;
    logic [0:0]  out_data1;
    logic [63:0] out_data64;
    logic [1:0]  occ32, occ1, occ64;

    assign in_data1  = in_data[0];
    assign in_data64 = {in_data, ~in_data};

    always #5 clk = ~clk;

    pipe_skid_reg u_dut32 (
        .clk(clk), .clr(clr), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_data(in_data),
        .out_valid(out_valid32), .out_ready(out_ready), .out_data(out_data32),
        .occupancy(occ32)
    );

    pipe_skid_reg #(.WIDTH(1), .RESET_VAL(1'b1)) u_dut1 (
        .clk(clk), .clr(clr), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .occupancy(occ1)
    );

    pipe_skid_reg #(.WIDTH(64), .RESET_VAL({64{1'b1}})) u_dut64 (
        .clk(clk), .clr(clr), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_data(in_data64),
        .out_valid(out_valid64), .out_ready(out_ready), .out_data(out_data64),
        .occupancy(occ64)
    );

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic [1:0]  exp_occ;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void add(input logic fl, input logic iv, input logic [31:0] d,
                                input logic ordy, input logic [1:0] exp_occ);
        vec_t v;
        v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy; v.exp_occ = exp_occ;
        tbl.push_back(v);
    endfunction

    // Called just after a rising edge; samples mid-cycle, updates the scoreboard, returns after the next edge.
    task automatic step(input logic fl, input logic iv, input logic [31:0] d, input logic ordy);
        int          cnt;
        logic [31:0] head;
        flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
        @(negedge clk);
        cnt = sb.size();
        chk("occupancy32", {62'd0, occ32}, cnt);
        chk("occupancy1",  {62'd0, occ1},  cnt);
        chk("occupancy64", {62'd0, occ64}, cnt);
        chk("in_ready",  {61'd0, in_ready32, in_ready1, in_ready64},
                         {61'd0, {3{cnt < 2}}});
        chk("out_valid", {61'd0, out_valid32, out_valid1, out_valid64},
                         {61'd0, {3{cnt != 0}}});
        if (cnt > 0) begin
            head = sb[0];
            chk("out_data32", {32'd0, out_data32}, {32'd0, head});
            chk("out_data1",  {63'd0, out_data1},  {63'd0, head[0]});
            chk("out_data64", out_data64, {head, ~head});
        end
        if (ordy && cnt > 0) begin
            void'(sb.pop_front());
        end
        if (fl) begin
            sb.delete();
        end else if (iv && cnt < 2) begin
            sb.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;

        // Streaming 1..8 with out_ready held high.
        for (int k = 1; k <= 8; k++) add(0, 1, k, 1, 1);
        add(0, 0, 'x, 1, 0);
        // Backpressure: 0x33 waits upstream until space opens.
        add(0, 1, 32'h11, 0, 1);
        add(0, 1, 32'h22, 0, 2);
        add(0, 1, 32'h33, 0, 2);
        add(0, 1, 32'h33, 0, 2);
        add(0, 1, 32'h33, 1, 1);
        add(0, 1, 32'h33, 1, 1);
        add(0, 0, 'x, 1, 0);
        // Simultaneous in/out fire while holding one entry.
        add(0, 1, 32'h40, 0, 1);
        add(0, 1, 32'h44, 1, 1);
        add(0, 0, 'x, 0, 1);
        add(0, 0, 'x, 1, 0);
        // Flush from TWO with in_valid high; flushed data must never surface.
        add(0, 1, 32'hA1, 0, 1);
        add(0, 1, 32'hA2, 0, 2);
        add(1, 1, 32'hF5, 0, 0);
        add(0, 0, 'x, 1, 0);
        add(0, 1, 32'h66, 1, 1);
        add(0, 0, 'x, 1, 0);
        // Flush in ONE alongside in_fire and out_fire.
        add(0, 1, 32'h70, 0, 1);
        add(1, 1, 32'h71, 1, 0);
        add(0, 0, 'x, 1, 0);

        clr = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        #2;
        chk("rst_out_valid", {61'd0, out_valid32, out_valid1, out_valid64}, 64'd0);
        chk("rst_in_ready",  {61'd0, in_ready32, in_ready1, in_ready64}, 64'd0);
        chk("rst_out_data32", {32'd0, out_data32}, 64'd0);
        chk("rst_out_data1",  {63'd0, out_data1}, 64'd1);
        chk("rst_out_data64", out_data64, {64{1'b1}});
        chk("rst_occupancy", {58'd0, occ32, occ1, occ64}, 64'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;

        // Clear asserted mid-operation between edges acts without a clock.
        step(0, 1, 32'h0000_000A, 0);
        step(0, 1, 32'h0000_000B, 0);
        chk("fill_two_occ", {62'd0, occ32}, 64'd2);
        #1 clr = 1'b1;
        #1;
        chk("clr_out_valid", {63'd0, out_valid32}, 64'd0);
        chk("clr_out_data",  {32'd0, out_data32}, 64'd0);
        chk("clr_occupancy", {62'd0, occ32}, 64'd0);
        chk("clr_in_ready",  {63'd0, in_ready32}, 64'd0);
        chk("clr_out_data64", out_data64, {64{1'b1}});
        sb.delete();
        #1 clr = 1'b0;
        step(0, 1, 32'h5, 0);
        chk("post_clr_data", {32'd0, out_data32}, 64'd5);
        step(0, 0, 'x, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            step(v.fl, v.iv, v.d, v.ordy);
            chk($sformatf("occ_after[%0d]", i), {62'd0, occ32}, {62'd0, v.exp_occ});
        end

        chk("sb_drained", sb.size(), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
